p_layer_iter: RTL and testbench

Iterative, parametrised PRESENT-style bit-permutation engine. It accepts one WIDTH-bit word with a direction bit and an iteration count, then applies the forward or inverse p-layer permutation that many times, one application per clock. It holds the result behind a valid/ready handshake. It sits in the cipher datapath alongside the fixed 64-bit combinational p-layer and serves round-serialised and decryption paths, plus other state widths.

---
 rtl/p_layer_pkg.sv | 40 ++++
 rtl/p_perm.sv | 31 +++
 rtl/p_layer_iter.sv | 114 +++++++++++
 tb/tb_p_layer_iter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p_layer_pkg
// Description : Shared types and helpers for the iterative PRESENT-style
//               p-layer engine: FSM state encoding, permutation index
//               function and state-width legality constants.
// Revision    : 1.0 - initial release
// ============================================================================
package p_layer_pkg;

    // Width legality: the permutation needs WIDTH/4 as a stride and at
    // least two nibbles to be meaningful.
    localparam int c_MIN_WIDTH   = 8;
    localparam int c_WIDTH_ALIGN = 4;

    // Explicit state encoding, shared by the enum below.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_ST_IDLE,
        RUN  = c_ST_RUN,
        DONE = c_ST_DONE
    } state_t;

    // P(i) = (i*WIDTH/4) mod (WIDTH-1); the top bit is a fixed point.
    function automatic int perm_idx(input int i, input int width);
        if (i == width - 1) begin
            return width - 1;
        end
        return (i * (width / 4)) % (width - 1);
    endfunction

    function automatic bit width_ok(input int width);
        return ((width % c_WIDTH_ALIGN) == 0) && (width >= c_MIN_WIDTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/p_perm.sv
`default_nettype none
// ============================================================================
// Module      : p_perm
// Description : Single combinational application of the p-layer bit
//               permutation, forward or inverse, for any legal WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module p_perm
    import p_layer_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] in,
    input  logic             inv,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_inv;

    // Pure wiring: every output bit is routed from exactly one input bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int c_P = perm_idx(i, WIDTH);
        assign w_fwd[c_P] = in[i];
        assign w_inv[i]   = in[c_P];
    end

    assign out = inv ? w_inv : w_fwd;

endmodule
`default_nettype wire

// File: rtl/p_layer_iter.sv
`default_nettype none
// ============================================================================
// Module      : p_layer_iter
// Description : Iterative p-layer engine. Accepts a word, direction and
//               iteration count, applies the permutation once per clock and
//               presents the result behind a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module p_layer_iter
    import p_layer_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_inv,
    input  logic [ITER_W-1:0] in_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              busy
);

    // Reject illegal state widths at elaboration.
    if (!width_ok(WIDTH)) begin : g_width_check
        $error("p_layer_iter: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [ITER_W-1:0]  r_count;
    logic               r_inv;
    logic [WIDTH-1:0]   w_perm;
    logic               w_accept;

    p_perm #(
        .WIDTH (WIDTH)
    ) u_perm (
        .in  (r_data),
        .inv (r_inv),
        .out (w_perm)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; DONE can hand off directly to a new load.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~rst;
                w_accept = in_valid & ~rst;
                if (w_accept) begin
                    w_state_nxt = (in_iter == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_count == ITER_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~rst;
                w_accept  = in_valid & out_ready & ~rst;
                if (w_accept) begin
                    w_state_nxt = (in_iter == '0) ? DONE : RUN;
                end else if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, otherwise permute and count down while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
            r_inv   <= 1'b0;
        end else if (w_accept) begin
            r_data  <= in_data;
            r_count <= in_iter;
            r_inv   <= in_inv;
        end else if (r_state == RUN && r_count != '0) begin
            r_data  <= w_perm;
            r_count <= r_count - ITER_W'(1);
        end
    end

    assign out_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_p_layer_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_p_layer_iter
// Description : Self-checking bench for p_layer_iter with directed scenarios
//               and randomized words against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p_layer_iter;

    localparam int WIDTH  = 64;
    localparam int ITER_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              in_inv;
    logic [ITER_W-1:0] in_iter;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    p_layer_iter #(
        .WIDTH  (WIDTH),
        .ITER_W (ITER_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_iter   (in_iter),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Reference: apply the bit-mapping rule n times with plain arithmetic.
    function automatic logic [63:0] ref_perm(input logic [63:0] d, input bit inv, input int n);
        logic [63:0] cur;
        logic [63:0] nxt;
        int          p;
        cur = d;
        for (int k = 0; k < n; k++) begin
            nxt = '0;
            for (int i = 0; i < 64; i++) begin
                p = (i == 63) ? 63 : ((i * 16) % 63);
                if (inv) nxt[i] = cur[p];
                else     nxt[p] = cur[i];
            end
            cur = nxt;
        end
        return cur;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and complete the accept edge, then scramble inputs.
    task automatic send(input logic [63:0] d, input bit inv, input int n);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check_val("accept_wait", 64'(guard < 50), 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_iter  = ITER_W'(n);
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_inv   = 1'($urandom);
        in_iter  = ITER_W'($urandom);
    endtask

    // Count cycles to out_valid, poking in_valid during RUN (must be ignored).
    task automatic wait_result(input int n, input logic [63:0] exp);
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            check_val("busy_run", 64'(busy), 64'd1);
            in_valid = 1'($urandom);
            step();
            in_valid = 1'b0;
            lat++;
        end
        check_val("latency", 64'(lat), 64'(n));
        check_val("result", out_data, exp);
        check_val("busy_done", 64'(busy), 64'd0);
    endtask

    task automatic hold_out(input int cycles, input logic [63:0] exp);
        for (int c = 0; c < cycles; c++) begin
            check_val("in_ready_hold", 64'(in_ready), 64'd0);
            step();
            check_val("hold_valid", 64'(out_valid), 64'd1);
            check_val("hold_data", out_data, exp);
        end
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_val("in_ready_done", 64'(in_ready), 64'd1);
        step();
        out_ready = 1'b0;
        check_val("out_valid_clr", 64'(out_valid), 64'd0);
    endtask

    // Stream words with both handshakes held high; checks order and cycle count.
    task automatic stream(input int k);
        logic [63:0] q[$];
        int sent, got, cyc, total;
        bit acc;
        sent = 0; got = 0; cyc = 0; total = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom};
        in_inv    = 1'($urandom);
        in_iter   = ITER_W'($urandom_range(0, 4));
        #1;
        while (got < k && cyc < 2000) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check_val("stream_spurious", 64'd1, 64'd0);
                end else begin
                    check_val("stream_data", out_data, q[0]);
                    void'(q.pop_front());
                end
                got++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(ref_perm(in_data, in_inv, int'(in_iter)));
                total += int'(in_iter) + 1;
                sent++;
            end
            step();
            cyc++;
            if (acc) begin
                if (sent < k) begin
                    in_data = {$urandom, $urandom};
                    in_inv  = 1'($urandom);
                    in_iter = ITER_W'($urandom_range(0, 4));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check_val("stream_count", 64'(got), 64'(k));
        check_val("stream_cycles", 64'(cyc), 64'(total + 1));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        logic [63:0] d;
        bit          inv;
        int          n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        in_iter   = '0;
        out_ready = 1'b0;
        step();
        step();
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_out_data", out_data, 64'd0);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single forward / inverse applications with known bit moves.
        send(64'h2, 1'b0, 1);
        wait_result(1, 64'h0000_0000_0001_0000);
        release_out();
        send(64'h0000_0000_0001_0000, 1'b1, 1);
        wait_result(1, 64'h2);
        release_out();

        // P^3 is the identity at this width.
        send(64'hDEAD_BEEF_0123_4567, 1'b0, 3);
        wait_result(3, 64'hDEAD_BEEF_0123_4567);
        release_out();

        // Zero iterations pass through unchanged.
        send(64'hA5A5_5A5A_F00F_0FF0, 1'b1, 0);
        wait_result(0, 64'hA5A5_5A5A_F00F_0FF0);
        release_out();

        // Backpressure in DONE, then output handshake and new accept on one edge.
        d = 64'h0123_4567_89AB_CDEF;
        send(d, 1'b0, 1);
        wait_result(1, ref_perm(d, 1'b0, 1));
        hold_out(5, ref_perm(d, 1'b0, 1));
        d = 64'hFEDC_BA98_7654_3210;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_inv    = 1'b1;
        in_iter   = ITER_W'(2);
        #1;
        check_val("bypass_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '1;
        check_val("bypass_out_valid", 64'(out_valid), 64'd0);
        wait_result(2, ref_perm(d, 1'b1, 2));
        release_out();

        // Reset mid-RUN discards the word.
        send(64'h1111_2222_3333_4444, 1'b0, 20);
        repeat (4) step();
        check_val("mid_run_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        check_val("rrst_out_valid", 64'(out_valid), 64'd0);
        check_val("rrst_busy", 64'(busy), 64'd0);
        check_val("rrst_out_data", out_data, 64'd0);
        rst = 1'b0;
        #1;
        check_val("rrst_in_ready", 64'(in_ready), 64'd1);
        d = 64'h8000_0000_0000_0001;
        send(d, 1'b0, 1);
        wait_result(1, d);
        release_out();

        // Randomized words with random backpressure.
        for (int w = 0; w < 20; w++) begin
            d   = {$urandom, $urandom};
            inv = 1'($urandom);
            n   = $urandom_range(0, 31);
            send(d, inv, n);
            wait_result(n, ref_perm(d, inv, n));
            hold_out($urandom_range(0, 3), ref_perm(d, inv, n));
            release_out();
        end

        stream(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
